// File: rtl/icache_l1_if.sv
// icache_l1_if: fetch-side request/response bus and physical-memory line-fill bus for icache_l1.
//   cpu_*  : request (address, stb, cyc) from fetch; line data, resp (hit) and retry back to fetch
//   pmem_* : line-aligned fill address and read strobe to memory; fill line and resp from memory
//   master : the fetch/memory side; slave : the cache
interface icache_l1_if;
   logic [15:0]  cpu_address;
   logic         cpu_action_stb;
   logic         cpu_action_cyc;
   logic [127:0] cpu_rdata;
   logic         cpu_resp;
   logic         cpu_retry;
   logic [15:0]  pmem_address;
   logic         pmem_read;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;
   modport master (
      output cpu_address, cpu_action_stb, cpu_action_cyc, pmem_rdata, pmem_resp,
      input  cpu_rdata, cpu_resp, cpu_retry, pmem_address, pmem_read
   );
   modport slave (
      input  cpu_address, cpu_action_stb, cpu_action_cyc, pmem_rdata, pmem_resp,
      output cpu_rdata, cpu_resp, cpu_retry, pmem_address, pmem_read
   );
endinterface

// File: rtl/icache_l1.sv
// icache_l1: direct-mapped read-only L1 instruction cache returning whole 128-bit lines.
//   clk, rst    : clock and synchronous active-high reset
//   bus         : icache_l1_if.slave (fetch request/response and pmem line fill)
//   hit_count   : saturating count of cycles with cpu_resp=1
//   miss_count  : saturating count of IDLE->FILL transitions
module icache_l1 #(
   parameter int NUM_SETS = 8
) (
   input  logic        clk,
   input  logic        rst,
   icache_l1_if.slave  bus,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);
   localparam int IW = $clog2(NUM_SETS);
   localparam int TW = 12 - IW;
   typedef enum logic {IDLE, FILL} state_t;
   state_t              r_state, w_next;
   logic [NUM_SETS-1:0] r_valid;
   logic [TW-1:0]       r_tag [NUM_SETS];
   logic [127:0]        r_data [NUM_SETS];
   logic [11:0]         r_lat;
   logic [15:0]         r_hits, r_misses;
   logic                w_req, w_hit, w_resp, w_miss, w_install;
   logic [IW-1:0]       w_idx, w_lat_idx;
   logic [TW-1:0]       w_tag;
   assign w_req     = bus.cpu_action_stb & bus.cpu_action_cyc;
   assign w_idx     = bus.cpu_address[4 +: IW];
   assign w_tag     = bus.cpu_address[15 -: TW];
   assign w_lat_idx = r_lat[IW-1:0];
   assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   always_comb begin
      w_next        = r_state;
      w_resp        = 1'b0;
      w_miss        = 1'b0;
      w_install     = 1'b0;
      bus.pmem_read = 1'b0;
      if (r_state == IDLE) begin
         w_resp = w_req & w_hit;
         w_miss = w_req & ~w_hit;
         w_next = w_miss ? FILL : IDLE;
      end else begin
         bus.pmem_read = 1'b1;
         w_install     = bus.pmem_resp;
         w_next        = bus.pmem_resp ? IDLE : FILL;
      end
   end
   // retry covers both an IDLE miss and any request arriving while a fill is in flight
   assign bus.cpu_resp     = w_resp;
   assign bus.cpu_retry    = w_req & ~w_resp;
   assign bus.cpu_rdata    = r_data[w_idx];
   assign bus.pmem_address = {r_lat, 4'h0};
   assign hit_count        = r_hits;
   assign miss_count       = r_misses;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_valid  <= '0;
         r_lat    <= '0;
         r_hits   <= '0;
         r_misses <= '0;
      end else begin
         r_state <= w_next;
         if (w_miss) r_lat <= bus.cpu_address[15:4];
         if (w_install) r_valid[w_lat_idx] <= 1'b1;
         if (w_resp && r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
         if (w_miss && r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
      end
   end
   // line storage needs no reset: valid bits gate every use, and a fill in a reset cycle must not land
   always_ff @(posedge clk) begin
      if (!rst && w_install) begin
         r_data[w_lat_idx] <= bus.pmem_rdata;
         r_tag[w_lat_idx]  <= r_lat[11:IW];
      end
   end
endmodule

// File: doc/icache_l1.md
# icache_l1

Direct-mapped, read-only L1 instruction cache. It sits directly downstream of the CPU datapath's instruction port (`imem_*`) and returns whole 128-bit lines to the fetch stage. Hits complete in the request cycle. Misses hold the fetch stage with `retry` while the line is filled from physical memory over a single-line read handshake.

## Interface
Parameters:
- `NUM_SETS`, default 8: number of lines; must be a power of two, minimum 2.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `cpu_address`  in  16  — byte address from fetch (`lc3b_word`).
- `cpu_action_stb`  in  1  — request strobe.
- `cpu_action_cyc`  in  1  — bus cycle valid; a request exists only when stb and cyc are both 1.
- `cpu_rdata`  out  128  — line containing `cpu_address` (`lc3b_data`); valid only when `cpu_resp`=1.
- `cpu_resp`  out  1  — hit, data valid this cycle.
- `cpu_retry`  out  1  — request present but not served this cycle.
- `pmem_address`  out  16  — line-aligned fill address; bits [3:0] are always 0.
- `pmem_read`  out  1  — fill request, held until `pmem_resp`.
- `pmem_rdata`  in  128  — fill line.
- `pmem_resp`  in  1  — fill data valid.
- `hit_count`  out  16  — saturating hit counter.
- `miss_count`  out  16  — saturating miss counter.

## Operation
- **Address split**
  - offset = [3:0], ignored by the cache.
  - index = [3+log2(NUM_SETS):4].
  - tag = [15:4+log2(NUM_SETS)]. With the default `NUM_SETS`=8: index [6:4], tag [15:7].
- **Storage:** per set, one valid bit, one tag and one 128-bit data line, all held in registers.
- **FSM states**
  - IDLE
    - Request and valid[index] and tag match: `cpu_resp`=1, `cpu_rdata`=data[index], `cpu_retry`=0.
    - Request and miss: `cpu_retry`=1; latch {tag,index}; next state FILL.
    - No request: `cpu_resp`=0, `cpu_retry`=0.
  - FILL
    - `pmem_read`=1; `pmem_address`={latched tag, latched index, 4'b0}.
    - `cpu_resp`=0. `cpu_retry`=1 whenever a request is present, whatever its address.
    - On `pmem_resp`=1: write data, tag and valid=1 at the latched index; next state IDLE.
- **Lookup is combinational** on `cpu_address` in IDLE; `cpu_resp` and `cpu_retry` are never both 1.
- **Dropped request:** if the request is removed during FILL, the fill still completes and the line is installed.
- **Address change during FILL:** has no effect; the fill uses the latched address.
- **Conflict eviction:** a fill overwrites the resident line unconditionally. No write path and no dirty state exist.
- **Counters**
  - `hit_count` +1 every cycle in which `cpu_resp`=1.
  - `miss_count` +1 on every IDLE→FILL transition.
  - Both saturate at 16'hFFFF.

## Timing
- **Reset values** (`rst`=1 at an edge)
  - State = IDLE, all valid bits = 0, latched address = 0.
  - `hit_count` = `miss_count` = 0; `pmem_read`=0; `pmem_address`=0.
  - `cpu_resp`=0; `cpu_retry` follows the request combinationally, because every set misses.
- **Hit latency:** 0 cycles; `cpu_resp` is asserted in the same cycle as the request.
- **Miss latency**
  - Cycle 0: request misses, `cpu_retry`=1.
  - Cycles 1..N: FILL, `pmem_read`=1; `pmem_resp` arrives in cycle N.
  - Cycle N+1: IDLE; if the same request is still present, `cpu_resp`=1.
  - Total = N+1 cycles; minimum 2 (with `pmem_resp` in cycle 1).
- **pmem handshake**
  - `pmem_read` and `pmem_address` stay stable from entry to FILL until the cycle `pmem_resp` is sampled.
  - `pmem_read` deasserts in the cycle after `pmem_resp`.
  - `pmem_resp` is ignored in IDLE.
- **Reset during FILL:** return to IDLE and clear all valid bits; `pmem_read`=0 in the next cycle. A `pmem_resp` arriving in the reset cycle installs nothing.
- **Counter saturation:** at 16'hFFFF an increment leaves the value unchanged; no wrap to 0.

## Test plan
- **Cold miss then hit:** after reset, request 16'h0042; `pmem_resp` arrives 3 cycles after `pmem_read` rises, with `pmem_rdata`=128'hA5…A5.
  - Expect `pmem_address`=16'h0040 and `cpu_retry`=1 for 4 cycles.
  - Then `cpu_resp`=1 with `cpu_rdata`=128'hA5…A5; `miss_count`=1, `hit_count`=1.
- **Same-line hit:** after the fill above, request 16'h004E → `cpu_resp`=1 in the same cycle, no `pmem_read`.
- **Conflict eviction:** fill 16'h0040, then request 16'h00C0 (same index 4, different tag).
  - Expect a miss and a fill at `pmem_address`=16'h00C0.
  - A re-request of 16'h0040 then misses again.
- **Address change and drop during FILL**
  - Request 16'h0100, then change to 16'h0200 mid-FILL → `pmem_address` stays 16'h0100, `cpu_retry`=1 throughout; afterwards 16'h0100 hits.
  - Remove the request mid-FILL → the line is still installed.
- **Reset mid-FILL:** assert `rst` with `pmem_read`=1.
  - Next cycle: `pmem_read`=0 and both counters = 0.
  - A late `pmem_resp` installs nothing; a prior valid line now misses.
- **Saturation:** hold a hit for 65,540 cycles → `hit_count`=16'hFFFF, no wrap.
